greetings_scroller: RTL

//  Parametrised successor to the fixed greetings display path of the FPGA pseudo-terminal.
//  A one-hot op_code, qualified by op_valid, selects a message from an internal ROM.
//  The block drives a NUM_CHARS-wide ASCII window of that message onto display.
//  The window scrolls circularly at a programmable tick rate; display feeds the terminal/LED driver.

---
 rtl/greetings_pkg.sv | 53 +++++
 rtl/greetings_msg_rom.sv | 17 +
 rtl/greetings_scroller.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/greetings_pkg.sv
// Shared definitions for the greetings scroller: character constants, FSM state encoding,
// the message table and small character helpers.
package greetings_pkg;

  localparam logic [7:0] ASCII_SPACE  = 8'h20;
  localparam int         BASE_MSG_LEN = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    SCROLL = 2'd2
  } state_e;

  // Entry num_ops is the ERR message; indices without a message read as blanks.
  function automatic logic [8*BASE_MSG_LEN-1:0] msg_text(input int sel, input int num_ops);
    logic [8*BASE_MSG_LEN-1:0] txt;
    if (sel == num_ops) begin
      txt = "ERR     ";
    end else begin
      case (sel)
        0:       txt = "READY   ";
        1:       txt = "BOOT OK ";
        2:       txt = "LINK UP ";
        3:       txt = "TX BUSY ";
        4:       txt = "RX DATA ";
        5:       txt = "HELLO   ";
        6:       txt = "WELCOME ";
        7:       txt = "GOODBYE ";
        8:       txt = "PAUSED  ";
        9:       txt = "BYE BYE ";
        10:      txt = "SYS OK  ";
        default: txt = "        ";
      endcase
    end
    return txt;
  endfunction

  function automatic logic [7:0] msg_char(input int sel, input int pos, input int num_ops);
    logic [8*BASE_MSG_LEN-1:0] txt;
    logic [7:0]                ch;
    txt = msg_text(sel, num_ops);
    ch  = ASCII_SPACE;
    if (pos >= 0 && pos < BASE_MSG_LEN) begin
      ch = txt[8*(BASE_MSG_LEN-1-pos) +: 8];
    end
    return ch;
  endfunction

  function automatic logic [7:0] hex_char(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction

endpackage

// File: rtl/greetings_msg_rom.sv
// Combinational message ROM: (message select, character position) -> one character.
module greetings_msg_rom
  import greetings_pkg::*;
#(
  parameter int CHAR_W  = 8,
  parameter int NUM_OPS = 11,
  parameter int SEL_W   = 4,
  parameter int POS_W   = 3
) (
  input  logic [SEL_W-1:0]  msg_sel,
  input  logic [POS_W-1:0]  char_idx,
  output logic [CHAR_W-1:0] char_out
);

  assign char_out = CHAR_W'(msg_char(int'(msg_sel), int'(char_idx), NUM_OPS));

endmodule

// File: rtl/greetings_scroller.sv
// Scrolling greetings window: a one-hot op selects a ROM message that scrolls circularly every TICK_DIV cycles.
// Optional macro GREETINGS_ARG_ECHO_EN replaces the last two message characters with the hex of argument a.
module greetings_scroller
  import greetings_pkg::*;
#(
  parameter int NUM_CHARS = 5,
  parameter int CHAR_W    = 8,
  parameter int NUM_OPS   = 11,
  parameter int MSG_LEN   = 8,
  parameter int TICK_DIV  = 25000000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        op_valid,
  input  logic [NUM_OPS-1:0]          op_code,
  input  logic [7:0]                  a,
  output logic [NUM_CHARS*CHAR_W-1:0] display,
  output logic                        busy,
  output logic                        wrap
);

  localparam int DISP_W = NUM_CHARS * CHAR_W;
  localparam int SEL_W  = $clog2(NUM_OPS + 1);
  localparam int OFF_W  = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
  localparam int TICK_W = $clog2(TICK_DIV + 1);

  localparam logic [DISP_W-1:0] BLANK     = {NUM_CHARS{CHAR_W'(ASCII_SPACE)}};
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [OFF_W-1:0]  OFF_LAST  = OFF_W'(MSG_LEN - 1);

  state_e              state_q, state_d;
  logic [NUM_OPS-1:0]  op_code_q, op_code_d;
  logic [SEL_W-1:0]    msg_sel_q, msg_sel_d;
  logic [OFF_W-1:0]    offset_q, offset_d;
  logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic                wrap_pend_q, wrap_pend_d;
  logic                wrap_q, wrap_d;
  logic                busy_q, busy_d;
  logic [DISP_W-1:0]   display_q, display_d;

  logic                op_start;
  logic                step;
  logic [SEL_W-1:0]    load_sel;
  logic [SEL_W-1:0]    dec_idx;
  logic                dec_seen;
  logic                dec_multi;
  logic [DISP_W-1:0]   window;

`ifdef GREETINGS_ARG_ECHO_EN
  logic [7:0] a_q, a_d;
`else
  logic unused_a;
  assign unused_a = ^a;
`endif

  assign op_start = op_valid && (op_code != '0);
  assign step     = (tick_cnt_q == TICK_LAST);

  // Multiple set bits map to the ERR entry, which sits just past the last op index.
  always_comb begin
    dec_idx   = '0;
    dec_seen  = 1'b0;
    dec_multi = 1'b0;
    for (int i = 0; i < NUM_OPS; i++) begin
      if (op_code_q[i]) begin
        if (dec_seen) dec_multi = 1'b1;
        dec_seen = 1'b1;
        dec_idx  = SEL_W'(i);
      end
    end
    load_sel = dec_multi ? SEL_W'(NUM_OPS) : dec_idx;
  end

  for (genvar g = 0; g < NUM_CHARS; g++) begin : g_slot
    logic [OFF_W:0]    pos_sum;
    logic [OFF_W-1:0]  pos;
    logic [CHAR_W-1:0] rom_ch;

    assign pos_sum = {1'b0, offset_q} + (OFF_W+1)'(g);
    assign pos     = (pos_sum >= (OFF_W+1)'(MSG_LEN)) ? OFF_W'(pos_sum - (OFF_W+1)'(MSG_LEN))
                                                      : pos_sum[OFF_W-1:0];

    greetings_msg_rom #(
      .CHAR_W  (CHAR_W),
      .NUM_OPS (NUM_OPS),
      .SEL_W   (SEL_W),
      .POS_W   (OFF_W)
    ) u_rom (
      .msg_sel  (msg_sel_q),
      .char_idx (pos),
      .char_out (rom_ch)
    );

`ifdef GREETINGS_ARG_ECHO_EN
    logic [CHAR_W-1:0] ch;
    always_comb begin
      ch = rom_ch;
      if (pos == OFF_W'(MSG_LEN - 2)) begin
        ch = CHAR_W'(hex_char(a_q[7:4]));
      end else if (pos == OFF_LAST) begin
        ch = CHAR_W'(hex_char(a_q[3:0]));
      end
    end
    assign window[(NUM_CHARS-1-g)*CHAR_W +: CHAR_W] = ch;
`else
    assign window[(NUM_CHARS-1-g)*CHAR_W +: CHAR_W] = rom_ch;
`endif
  end

  // display/busy follow the state one cycle late, so LOAD holds the previous window.
  // A nonzero op arriving during LOAD restarts it; a clear arriving there is ignored.
  always_comb begin
    state_d     = state_q;
    op_code_d   = op_code_q;
    msg_sel_d   = msg_sel_q;
    offset_d    = offset_q;
    tick_cnt_d  = tick_cnt_q;
    wrap_pend_d = 1'b0;
    wrap_d      = 1'b0;
    busy_d      = busy_q;
    display_d   = display_q;
`ifdef GREETINGS_ARG_ECHO_EN
    a_d         = op_start ? a : a_q;
`endif

    case (state_q)
      IDLE: begin
        display_d  = BLANK;
        busy_d     = 1'b0;
        offset_d   = '0;
        tick_cnt_d = '0;
        if (op_start) begin
          state_d   = LOAD;
          op_code_d = op_code;
        end
      end

      LOAD: begin
        msg_sel_d  = load_sel;
        offset_d   = '0;
        tick_cnt_d = '0;
        state_d    = SCROLL;
        if (op_start) begin
          state_d   = LOAD;
          op_code_d = op_code;
        end
      end

      SCROLL: begin
        display_d = window;
        busy_d    = 1'b1;
        wrap_d    = wrap_pend_q;
        if (step) begin
          tick_cnt_d  = '0;
          offset_d    = (offset_q == OFF_LAST) ? '0 : offset_q + OFF_W'(1);
          wrap_pend_d = (offset_q == OFF_LAST);
        end else begin
          tick_cnt_d = tick_cnt_q + TICK_W'(1);
        end
        if (op_valid) begin
          wrap_pend_d = 1'b0;
          wrap_d      = 1'b0;
          if (op_code == '0) begin
            state_d = IDLE;
          end else begin
            state_d   = LOAD;
            op_code_d = op_code;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      op_code_q   <= '0;
      msg_sel_q   <= '0;
      offset_q    <= '0;
      tick_cnt_q  <= '0;
      wrap_pend_q <= 1'b0;
      wrap_q      <= 1'b0;
      busy_q      <= 1'b0;
      display_q   <= BLANK;
    end else begin
      state_q     <= state_d;
      op_code_q   <= op_code_d;
      msg_sel_q   <= msg_sel_d;
      offset_q    <= offset_d;
      tick_cnt_q  <= tick_cnt_d;
      wrap_pend_q <= wrap_pend_d;
      wrap_q      <= wrap_d;
      busy_q      <= busy_d;
      display_q   <= display_d;
    end
  end

`ifdef GREETINGS_ARG_ECHO_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= '0;
    end else begin
      a_q <= a_d;
    end
  end
`endif

  assign display = display_q;
  assign busy    = busy_q;
  assign wrap    = wrap_q;

endmodule
